// File: rtl/npc_pkg.sv
// Shared encodings and enums for the npc_core multi-cycle RV32I/RV32E subset core.
package npc_pkg;

    localparam logic [6:0]  OP_IMM      = 7'b0010011;
    localparam logic [6:0]  OP_LUI      = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC    = 7'b0010111;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [6:0]  OP_JALR     = 7'b1100111;
    localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT_RESP,
        S_EXEC,
        S_HALT
    } npc_state_e;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_U,
        IMM_J
    } imm_type_e;

endpackage

// File: rtl/npc_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, asynchronous active-low clear.
module npc_regfile
    import npc_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    input  logic [4:0]      rd_addr_b,
    output logic [XLEN-1:0] rd_data_b,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    localparam int         AW     = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_ok;
    logic            a_ok;
    logic            b_ok;

    // Out-of-range indices never reach the array; they read as zero.
    assign wr_ok = wr_en && (wr_addr != 5'd0) && ({1'b0, wr_addr} < NREG_L);
    assign a_ok  = (rd_addr_a != 5'd0) && ({1'b0, rd_addr_a} < NREG_L);
    assign b_ok  = (rd_addr_b != 5'd0) && ({1'b0, rd_addr_b} < NREG_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data_a = a_ok ? regs[rd_addr_a[AW-1:0]] : '0;
    assign rd_data_b = b_ok ? regs[rd_addr_b[AW-1:0]] : '0;

endmodule

// File: rtl/npc_core.sv
// Multi-cycle core executing addi/lui/auipc/jal/jalr/ebreak with a valid/ready
// instruction fetch port and a commit trace port.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   FETCH     | request valid at pc, wait for imem_req_ready
//   WAIT_RESP | request accepted, wait for imem_resp_valid, latch ir
//   EXEC      | decode/execute ir, commit, write rd and pc at edge
//   HALT      | stopped by ebreak or illegal; only reset leaves
module npc_core
    import npc_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               NREG     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_wdata,
    output logic            halted,
    output logic            illegal,
    output logic [XLEN-1:0] halt_code
);

    localparam logic [5:0] NREG_L = 6'(NREG);

    npc_state_e      state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [31:0]     ir, ir_next;
    logic            halted_next;
    logic            illegal_next;
    logic [XLEN-1:0] halt_code_next;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [2:0]      funct3;
    logic            rd_ok;
    logic            rs1_ok;
    imm_type_e       imm_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] a0_val;
    logic [XLEN-1:0] sum_rs1;
    logic [XLEN-1:0] sum_pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_tgt;

    logic            dec_illegal;
    logic            dec_we;
    logic            dec_ebreak;
    logic [XLEN-1:0] dec_result;
    logic [XLEN-1:0] dec_target;
    logic            rf_we;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rd_ok  = {1'b0, rd} < NREG_L;
    assign rs1_ok = {1'b0, rs1} < NREG_L;

    always_comb begin
        imm_sel = IMM_I;
        case (opcode)
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            OP_JAL:           imm_sel = IMM_J;
            default:          imm_sel = IMM_I;
        endcase
        case (imm_sel)
            IMM_U:   imm = {ir[31:12], 12'b0};
            IMM_J:   imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    assign sum_rs1  = rs1_val + imm;
    assign sum_pc   = pc + imm;
    assign pc_plus4 = pc + XLEN'(4);
    assign jalr_tgt = sum_rs1 & ~XLEN'(1);

    // Anything not explicitly accepted below is illegal, including misaligned jump targets.
    always_comb begin
        dec_illegal = 1'b1;
        dec_we      = 1'b0;
        dec_ebreak  = 1'b0;
        dec_result  = '0;
        dec_target  = pc_plus4;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b000 && rd_ok && rs1_ok) begin
                    dec_illegal = 1'b0;
                    dec_we      = 1'b1;
                    dec_result  = sum_rs1;
                end
            end
            OP_LUI: begin
                if (rd_ok) begin
                    dec_illegal = 1'b0;
                    dec_we      = 1'b1;
                    dec_result  = imm;
                end
            end
            OP_AUIPC: begin
                if (rd_ok) begin
                    dec_illegal = 1'b0;
                    dec_we      = 1'b1;
                    dec_result  = sum_pc;
                end
            end
            OP_JAL: begin
                if (rd_ok && !sum_pc[1]) begin
                    dec_illegal = 1'b0;
                    dec_we      = 1'b1;
                    dec_result  = pc_plus4;
                    dec_target  = sum_pc;
                end
            end
            OP_JALR: begin
                if (funct3 == 3'b000 && rd_ok && rs1_ok && !jalr_tgt[1]) begin
                    dec_illegal = 1'b0;
                    dec_we      = 1'b1;
                    dec_result  = pc_plus4;
                    dec_target  = jalr_tgt;
                end
            end
            OP_SYSTEM: begin
                if (ir == EBREAK_INSN) begin
                    dec_illegal = 1'b0;
                    dec_ebreak  = 1'b1;
                    dec_target  = pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            halt_code <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            ir        <= ir_next;
            halted    <= halted_next;
            illegal   <= illegal_next;
            halt_code <= halt_code_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ir_next        = ir;
        halted_next    = halted;
        illegal_next   = illegal;
        halt_code_next = halt_code;
        imem_req_valid = 1'b0;
        commit_valid   = 1'b0;
        commit_pc      = '0;
        commit_rd      = '0;
        commit_wdata   = '0;
        rf_we          = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_next = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (imem_resp_valid) begin
                    ir_next    = imem_rdata;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_illegal) begin
                    halted_next    = 1'b1;
                    illegal_next   = 1'b1;
                    halt_code_next = a0_val;
                    state_next     = S_HALT;
                end else begin
                    commit_valid = 1'b1;
                    commit_pc    = pc;
                    if (dec_ebreak) begin
                        halted_next    = 1'b1;
                        halt_code_next = a0_val;
                        state_next     = S_HALT;
                    end else begin
                        commit_rd    = rd;
                        commit_wdata = (rd != 5'd0) ? dec_result : '0;
                        rf_we        = dec_we;
                        pc_next      = dec_target;
                        state_next   = S_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    assign imem_addr = pc;

    npc_regfile #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_val),
        .rd_addr_b (5'd10),
        .rd_data_b (a0_val),
        .wr_en     (rf_we),
        .wr_addr   (rd),
        .wr_data   (dec_result)
    );

endmodule

// File: tb/tb_npc_core.sv
// Directed bench for npc_core: an RV32I instance and an RV32E instance share one
// hand-driven instruction memory; expected values are hand-computed.
module tb_npc_core;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_e;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [4:0]  commit_rd;
    logic [31:0] commit_wdata;
    logic        halted;
    logic        illegal;
    logic [31:0] halt_code;

    logic        e_req_valid;
    logic [31:0] e_addr;
    logic        e_commit_valid;
    logic [31:0] e_commit_pc;
    logic [4:0]  e_commit_rd;
    logic [31:0] e_commit_wdata;
    logic        e_halted;
    logic        e_illegal;
    logic [31:0] e_halt_code;

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;

    logic        c_valid;
    logic [31:0] c_pc;
    logic [4:0]  c_rd;
    logic [31:0] c_wdata;
    logic        e_c_valid;
    int          exec_cyc;
    logic        addr_ok;
    int          t_start;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    npc_core #(.XLEN(32), .NREG(32), .RESET_PC(32'h8000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_rd       (commit_rd),
        .commit_wdata    (commit_wdata),
        .halted          (halted),
        .illegal         (illegal),
        .halt_code       (halt_code)
    );

    npc_core #(.XLEN(32), .NREG(16), .RESET_PC(32'h8000_0000)) dut_e (
        .clk             (clk),
        .rst             (rst_e),
        .imem_req_valid  (e_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (e_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .commit_valid    (e_commit_valid),
        .commit_pc       (e_commit_pc),
        .commit_rd       (e_commit_rd),
        .commit_wdata    (e_commit_wdata),
        .halted          (e_halted),
        .illegal         (e_illegal),
        .halt_code       (e_halt_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        rst_e           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_rdata      = '0;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        rst_e = 1'b1;
    endtask

    // Called at a negedge with the core in FETCH; returns at the negedge after EXEC.
    task automatic run_instr(input logic [31:0] instr, input int stall, input int delay,
                             input bit spurious);
        int          t0;
        logic [31:0] a_hold;
        t0              = cyc;
        a_hold          = imem_addr;
        addr_ok         = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = spurious;
        imem_rdata      = EBREAK_INSN;
        repeat (stall) begin
            @(negedge clk);
            if (imem_addr !== a_hold || imem_req_valid !== 1'b1) addr_ok = 1'b0;
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        if (imem_addr !== a_hold) addr_ok = 1'b0;
        imem_resp_valid = 1'b0;
        repeat (delay) begin
            @(negedge clk);
            if (imem_addr !== a_hold) addr_ok = 1'b0;
        end
        imem_resp_valid = 1'b1;
        imem_rdata      = instr;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_rdata      = '0;
        c_valid         = commit_valid;
        c_pc            = commit_pc;
        c_rd            = commit_rd;
        c_wdata         = commit_wdata;
        e_c_valid       = e_commit_valid;
        exec_cyc        = cyc - t0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst             = 1'b1;
        rst_e           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_rdata      = '0;
        #1;

        // Reset values and first fetch
        rst   = 1'b0;
        rst_e = 1'b0;
        @(negedge clk);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_halt_code", halt_code, 32'd0);
        check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        rst_e = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_addr", imem_addr, 32'h8000_0000);

        // Basic sequence, zero-wait memory
        t_start = cyc;
        run_instr(32'h0050_0093, 0, 0, 1'b0);
        check("addi5_valid", {31'd0, c_valid}, 32'd1);
        check("addi5_pc", c_pc, 32'h8000_0000);
        check("addi5_rd", {27'd0, c_rd}, 32'd1);
        check("addi5_wdata", c_wdata, 32'd5);
        check("addi5_latency", exec_cyc, 32'd2);
        run_instr(32'hFF90_8093, 0, 0, 1'b0);
        check("addim7_pc", c_pc, 32'h8000_0004);
        check("addim7_wdata", c_wdata, 32'hFFFF_FFFE);
        run_instr(EBREAK_INSN, 0, 0, 1'b0);
        check("ebreak_valid", {31'd0, c_valid}, 32'd1);
        check("ebreak_rd", {27'd0, c_rd}, 32'd0);
        check("ebreak_wdata", c_wdata, 32'd0);
        check("ebreak_halted", {31'd0, halted}, 32'd1);
        check("ebreak_illegal", {31'd0, illegal}, 32'd0);
        check("ebreak_halt_code", halt_code, 32'd0);
        check("basic_cycles", cyc - t_start, 32'd9);
        repeat (3) @(negedge clk);
        check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("halt_sticky", {31'd0, halted}, 32'd1);

        // Upper immediates, jumps and a stalled handshake
        do_reset();
        run_instr(32'h1234_5137, 0, 0, 1'b0);
        check("lui_rd", {27'd0, c_rd}, 32'd2);
        check("lui_wdata", c_wdata, 32'h1234_5000);
        run_instr(32'h02A0_0513, 0, 0, 1'b0);
        check("addi_a0_wdata", c_wdata, 32'd42);
        run_instr(32'h0000_1197, 0, 0, 1'b0);
        check("auipc_pc", c_pc, 32'h8000_0008);
        check("auipc_wdata", c_wdata, 32'h8000_1008);
        run_instr(32'h0100_00EF, 0, 0, 1'b0);
        check("jal_pc", c_pc, 32'h8000_000C);
        check("jal_wdata", c_wdata, 32'h8000_0010);
        check("jal_next_addr", imem_addr, 32'h8000_001C);
        run_instr(32'h8000_02B7, 0, 0, 1'b0);
        check("lui_x5_wdata", c_wdata, 32'h8000_0000);
        run_instr(32'h1012_8293, 0, 0, 1'b0);
        check("addi_x5_wdata", c_wdata, 32'h8000_0101);
        run_instr(32'h0002_8067, 0, 0, 1'b0);
        check("jalr_valid", {31'd0, c_valid}, 32'd1);
        check("jalr_rd", {27'd0, c_rd}, 32'd0);
        check("jalr_next_addr", imem_addr, 32'h8000_0100);
        run_instr(32'hFFF0_0313, 3, 2, 1'b1);
        check("stall_addr_stable", {31'd0, addr_ok}, 32'd1);
        check("stall_latency", exec_cyc, 32'd7);
        check("stall_pc", c_pc, 32'h8000_0100);
        check("stall_wdata", c_wdata, 32'hFFFF_FFFF);
        run_instr(EBREAK_INSN, 0, 0, 1'b0);
        check("ebreak2_halt_code", halt_code, 32'd42);
        check("ebreak2_illegal", {31'd0, illegal}, 32'd0);

        // Reset during WAIT_RESP, late response, then misaligned jalr
        do_reset();
        run_instr(32'h0050_0093, 0, 0, 1'b0);
        check("pre_rst_wdata", c_wdata, 32'd5);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_addr", imem_addr, 32'h8000_0000);
        @(negedge clk);
        rst             = 1'b1;
        imem_resp_valid = 1'b1;
        imem_rdata      = EBREAK_INSN;
        @(negedge clk);
        @(negedge clk);
        check("late_resp_commit", {31'd0, commit_valid}, 32'd0);
        check("late_resp_halted", {31'd0, halted}, 32'd0);
        check("late_resp_req", {31'd0, imem_req_valid}, 32'd1);
        imem_resp_valid = 1'b0;
        run_instr(32'h0000_8113, 0, 0, 1'b0);
        check("post_rst_pc", c_pc, 32'h8000_0000);
        check("post_rst_x1", c_wdata, 32'd0);
        run_instr(32'h8000_02B7, 0, 0, 1'b0);
        run_instr(32'h1012_8293, 0, 0, 1'b0);
        check("x5_setup", c_wdata, 32'h8000_0101);
        run_instr(32'hF012_83E7, 0, 0, 1'b0);
        check("misalign_commit", {31'd0, c_valid}, 32'd0);
        check("misalign_halted", {31'd0, halted}, 32'd1);
        check("misalign_illegal", {31'd0, illegal}, 32'd1);
        check("misalign_pc", imem_addr, 32'h8000_000C);
        check("misalign_no_req", {31'd0, imem_req_valid}, 32'd0);

        // RV32E index limit and unsupported opcode
        do_reset();
        run_instr(32'h0010_0893, 0, 0, 1'b0);
        check("x17_rv32i_rd", {27'd0, c_rd}, 32'd17);
        check("x17_rv32i_wdata", c_wdata, 32'd1);
        check("x17_rv32e_commit", {31'd0, e_c_valid}, 32'd0);
        check("x17_rv32e_halted", {31'd0, e_halted}, 32'd1);
        check("x17_rv32e_illegal", {31'd0, e_illegal}, 32'd1);
        check("x17_rv32e_pc", e_addr, 32'h8000_0000);
        run_instr(32'h0031_00B3, 0, 0, 1'b0);
        check("opreg_commit", {31'd0, c_valid}, 32'd0);
        check("opreg_halted", {31'd0, halted}, 32'd1);
        check("opreg_illegal", {31'd0, illegal}, 32'd1);
        check("opreg_pc", imem_addr, 32'h8000_0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/npc_core.md
# npc_core

Multi-cycle, parametrised successor to the single-cycle `npc` top. It fetches one instruction at a time from an external instruction memory over a valid/ready request and valid response handshake. It executes a small RV32I/RV32E subset: `addi`, `auipc`, `lui`, `jal`, `jalr` and `ebreak`. It owns the PC, the register file and a commit/trace port used by the simulation harness.

## Interface
- `XLEN`, 32: datapath and PC width; only 32 is supported.
- `NREG`, 32: number of architectural registers. Legal values are 32 (RV32I) or 16 (RV32E).
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low (asserted when 0).
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request.
- `imem_addr`, out, XLEN: fetch address; always equals the current PC.
- `imem_resp_valid`, in, 1: instruction word is present on `imem_rdata`.
- `imem_rdata`, in, 32: instruction word.
- `commit_valid`, out, 1: one instruction retires in this cycle.
- `commit_pc`, out, XLEN: PC of the retiring instruction.
- `commit_rd`, out, 5: destination index; 0 if none.
- `commit_wdata`, out, XLEN: value written to `rd`; 0 if none.
- `halted`, out, 1: core has stopped.
- `illegal`, out, 1: the halt was caused by an illegal instruction or a misaligned target.
- `halt_code`, out, XLEN: value of register a0 (x10), captured at halt.

## Operation
- The FSM has four states: FETCH, WAIT_RESP, EXEC, HALT.
- FETCH:
  - `imem_req_valid`=1.
  - On `imem_req_valid && imem_req_ready` at a rising edge, go to WAIT_RESP.
  - `imem_addr` must not change while the request is pending.
- WAIT_RESP:
  - On `imem_resp_valid`, latch `imem_rdata` into the instruction register and go to EXEC.
  - `imem_resp_valid` is ignored in every other state.
- EXEC:
  - Decode and execute in a single cycle, then go to FETCH.
  - `commit_*` fields are driven combinationally during this cycle, with `commit_valid`=1.
  - The register write and PC update take effect at the end of this cycle.
- Instruction semantics:
  - `addi`: rd = rs1 + sext(I-imm).
  - `lui`: rd = {U-imm, 12'b0}.
  - `auipc`: rd = pc + {U-imm, 12'b0}.
  - `jal`: rd = pc+4; pc = pc + sext(J-imm).
  - `jalr`: rd = pc+4; pc = (rs1 + sext(I-imm)) & ~1.
  - All other instructions: pc = pc+4.
- All arithmetic is modulo 2^XLEN. The PC wraps silently from 32'hFFFF_FFFC to 0.
- Writes to x0 are discarded, and x0 always reads 0. `commit_rd` still reports the encoded rd.
- `ebreak`:
  - Retires with `commit_valid`=1 and no register write.
  - Sets `halted`=1 and captures `halt_code` = x10; next state is HALT.
- Illegal instruction: any other opcode/funct3, or an rd/rs1 index ≥ NREG.
  - No write, PC unchanged, `commit_valid`=0.
  - Sets `halted`=1 and `illegal`=1; next state is HALT.
- Misaligned `jal`/`jalr` target (bit 1 set after masking) is treated as illegal, with no rd write.
- HALT is absorbing; only reset leaves it. No fetch requests are issued in HALT.

## Timing
- Reset values (asynchronous, effective while `rst`=0):
  - state = FETCH, pc = RESET_PC.
  - All registers 0, instruction register 0.
  - `halted`=0, `illegal`=0, `halt_code`=0.
  - `commit_valid`=0, `imem_req_valid`=1 once `rst`=1.
- With a zero-wait memory (ready held high, response one cycle after acceptance), each instruction takes 3 cycles: FETCH, WAIT_RESP, EXEC.
  - Each request-ready stall cycle adds one cycle.
  - Each cycle without a response adds one cycle.
- A response arriving in the same cycle as request acceptance is illegal for the memory and is not sampled.
- Reset asserted mid-fetch or mid-EXEC aborts immediately:
  - No commit; the pending write is lost.
  - An outstanding response after reset is ignored, because the state is FETCH.
- `halted`, `illegal` and `halt_code` are registered and become visible the cycle after the EXEC that caused the halt.

## Structure
- Package `npc_pkg` holds:
  - Opcode constants (OP_IMM, LUI, AUIPC, JAL, JALR, SYSTEM).
  - The `ebreak` encoding 32'h0010_0073.
  - The FSM state enum.
  - The immediate-type enum (I, U, J).
- One sub-module, `npc_regfile`:
  - Parameters NREG and XLEN.
  - Two combinational read ports, one synchronous write port with enable.
  - x0 forced to zero; asynchronous active-low clear.
- Immediate extension and ALU stay inline in `npc_core`.

## Test plan
- Reset/first fetch: release `rst` with ready=1 → `imem_req_valid`=1 and `imem_addr`=32'h8000_0000 in the first cycle.
- Basic sequence: `addi x1,x0,5`; then `addi x1,x1,-7`; then `ebreak` with a0=0 → commits x1=5, then x1=32'hFFFF_FFFE; `halted`=1, `illegal`=0, `halt_code`=0; exactly 9 cycles with zero-wait memory.
- Upper immediate and jumps:
  - `lui x2,0x12345` → x2=32'h1234_5000.
  - `auipc x3,1` at 32'h8000_0008 → x3=32'h8000_1008.
  - `jal x1,+16` at 32'h8000_000C → x1=32'h8000_0010, next `imem_addr`=32'h8000_001C.
  - `jalr x0,0(x5)` with x5=32'h8000_0101 → next `imem_addr`=32'h8000_0100.
- Handshake stalls: ready low for 3 cycles, then response delayed 2 cycles → `imem_addr` stable throughout; instruction commits after 3+1+2+1 extra cycles; a spurious `imem_resp_valid` during FETCH has no effect.
- Illegal/RV32E:
  - NREG=16, `addi x17,x0,1` → `commit_valid` never asserts; `halted`=1, `illegal`=1, pc unchanged.
  - Opcode 7'b0110011 → same response.
  - `jalr` to 32'h8000_0002 → illegal, with no rd write.
- Reset mid-operation: assert `rst`=0 during WAIT_RESP after x1 was written, then release → pc=RESET_PC, x1=0, state FETCH; a late response is ignored.
